// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU constants and divider state encoding
package alu_pkg;

    localparam int WIDTH = 16;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    localparam logic [WIDTH-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/sub17bits.sv
// rtl/sub17bits.sv - (WIDTH+1)-bit subtractor as a + ~b + 1 on 4-bit lookahead groups
module sub17bits #(
    parameter int N = 17
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         carry_out
);

    logic [N-1:0] gen;
    logic [N-1:0] prop;
    logic [N-1:0] carry_in;
    logic         grp_carry;
    logic         grp_cin;
    logic         grp_g;
    logic         grp_p;

    assign gen  = a & ~b;
    assign prop = a ^ ~b;

    // Carries inside a 4-bit group come straight from the group carry-in and
    // the running group generate/propagate; group carries chain between groups.
    always_comb begin
        grp_carry = 1'b1;
        grp_cin   = 1'b1;
        grp_g     = 1'b0;
        grp_p     = 1'b1;
        carry_in  = '0;
        for (int i = 0; i < N; i++) begin
            if (i % 4 == 0) begin
                grp_cin = grp_carry;
                grp_g   = 1'b0;
                grp_p   = 1'b1;
            end
            carry_in[i] = grp_g | (grp_p & grp_cin);
            grp_g = gen[i] | (prop[i] & grp_g);
            grp_p = prop[i] & grp_p;
            if ((i % 4 == 3) || (i == N - 1)) begin
                grp_carry = grp_g | (grp_p & grp_cin);
            end
        end
    end

    assign diff      = prop ^ carry_in;
    assign carry_out = grp_carry;

endmodule

// File: rtl/seq_divider16.sv
// rtl/seq_divider16.sv - multi-cycle unsigned restoring divider with valid/ready handshake
module seq_divider16
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [2*WIDTH:0] rq_sh;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH-1:0] q_sh;
    logic [WIDTH:0]   trial;
    logic             no_borrow;

    assign rq_sh = {r_q, q_q} << 1;
    assign r_sh  = rq_sh[2*WIDTH:WIDTH];
    assign q_sh  = rq_sh[WIDTH-1:0];

    sub17bits #(.N(WIDTH + 1)) u_sub (
        .a         (r_sh),
        .b         ({1'b0, d_q}),
        .diff      (trial),
        .carry_out (no_borrow)
    );

    // Next-state: accept, one restoring step per RUN cycle, result hand-off
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        d_d      = d_q;
        q_d      = q_q;
        r_d      = r_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        dz_d     = dz_q;
        unique case (state_q)
            DIV_IDLE: begin
                if (in_valid && in_ready_q) begin
                    d_d   = divisor;
                    q_d   = dividend;
                    r_d   = '0;
                    cnt_d = CNT_W'(WIDTH);
                    if (divisor == '0) begin
                        state_d = DIV_DONE;
                        quot_d  = DIV_ZERO_QUOT;
                        rem_d   = dividend;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = DIV_RUN;
                    end
                end
            end
            DIV_RUN: begin
                r_d   = no_borrow ? trial : r_sh;
                q_d   = {q_sh[WIDTH-1:1], no_borrow};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DIV_DONE;
                    quot_d  = q_d;
                    rem_d   = r_d[WIDTH-1:0];
                    dz_d    = 1'b0;
                end
            end
            DIV_DONE: begin
                if (out_ready) begin
                    state_d = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
        in_ready_d  = (state_d == DIV_IDLE);
        out_valid_d = (state_d == DIV_DONE);
    end

    // State and datapath registers; handshake outputs registered from next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= DIV_IDLE;
            cnt_q       <= '0;
            d_q         <= '0;
            q_q         <= '0;
            r_q         <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            dz_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            d_q         <= d_d;
            q_q         <= q_d;
            r_q         <= r_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            dz_q        <= dz_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_seq_divider16.sv
// tb/tb_seq_divider16.sv - directed and sweep bench for seq_divider16
module tb_seq_divider16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_zero;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_divider16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        int w;
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        w = 0;
        while (!in_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        n_assert++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic ack_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clk);
        n_assert++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_assert++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_assert++;
        if (quotient !== 16'h0 || remainder !== 16'h0 || div_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: q=%h r=%h dz=%b want 0 0 0", quotient, remainder, div_zero);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat;
        start_op(16'd100, 16'd7);
        wait_result(lat);
        n_assert++;
        if (lat != 17) begin n_fail++; $display("FAIL basic_latency: got %0d want 17", lat); end
        n_assert++;
        if (quotient !== 16'd14 || remainder !== 16'd2 || div_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_100_7: q=%0d r=%0d dz=%b want 14 2 0", quotient, remainder, div_zero);
        end
        ack_result();
        n_assert++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_handoff: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_extremes();
        int lat;
        start_op(16'hFFFF, 16'd1);
        wait_result(lat);
        n_assert++;
        if (out_valid !== 1'b1 || quotient !== 16'hFFFF || remainder !== 16'h0) begin
            n_fail++;
            $display("FAIL max_div_1: ov=%b q=%h r=%h want 1 ffff 0000", out_valid, quotient, remainder);
        end
        ack_result();
        start_op(16'd3, 16'd10);
        wait_result(lat);
        n_assert++;
        if (out_valid !== 1'b1 || quotient !== 16'd0 || remainder !== 16'd3) begin
            n_fail++;
            $display("FAIL small_div_big: ov=%b q=%0d r=%0d want 1 0 3", out_valid, quotient, remainder);
        end
        ack_result();
    endtask

    task automatic test_div_zero();
        int lat;
        start_op(16'd5, 16'd0);
        wait_result(lat);
        n_assert++;
        if (lat != 1) begin n_fail++; $display("FAIL dz_latency: got %0d want 1", lat); end
        n_assert++;
        if (quotient !== 16'hFFFF || remainder !== 16'd5 || div_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL dz_result: q=%h r=%0d dz=%b want ffff 5 1", quotient, remainder, div_zero);
        end
        ack_result();
        n_assert++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dz_release: out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_stall();
        int lat;
        int bad;
        start_op(16'd1000, 16'd33);
        repeat (3) @(negedge clk);
        n_assert++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_busy_ready: in_ready=%b want 0", in_ready); end
        in_valid = 1'b1;
        dividend = 16'd7;
        divisor  = 16'd2;
        @(negedge clk);
        in_valid = 1'b0;
        wait_result(lat);
        n_assert++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_done: out_valid=%b want 1", out_valid); end
        for (int i = 0; i < 5; i++) begin
            n_assert++;
            if (quotient !== 16'd30 || remainder !== 16'd10 || div_zero !== 1'b0
                || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: q=%0d r=%0d dz=%b ov=%b ir=%b want 30 10 0 1 0",
                         i, quotient, remainder, div_zero, out_valid, in_ready);
            end
            in_valid = (i == 2);
            dividend = 16'd9;
            divisor  = 16'd0;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_assert++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_handoff_ready: in_ready=%b want 0", in_ready); end
        @(negedge clk);
        out_ready = 1'b0;
        n_assert++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 16'd30) begin
            n_fail++;
            $display("FAIL stall_after_ack: ov=%b ir=%b q=%0d want 0 1 30", out_valid, in_ready, quotient);
        end
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        n_assert++;
        if (bad != 0) begin n_fail++; $display("FAIL stall_no_capture: %0d bad cycles want 0", bad); end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        start_op(16'h8000, 16'd3);
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_assert++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_reset_hs: ov=%b ir=%b want 0 1", out_valid, in_ready);
        end
        n_assert++;
        if (quotient !== 16'h0 || remainder !== 16'h0 || div_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset_data: q=%h r=%h dz=%b want 0 0 0", quotient, remainder, div_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_op(16'h8000, 16'd3);
        wait_result(lat);
        n_assert++;
        if (lat != 17 || quotient !== 16'h2AAA || remainder !== 16'd2) begin
            n_fail++;
            $display("FAIL midrun_retry: lat=%0d q=%h r=%0d want 17 2aaa 2", lat, quotient, remainder);
        end
        ack_result();
    endtask

    task automatic test_back_to_back();
        int      lat;
        int      a;
        int      b;
        longint  prod;
        logic    ok;
        for (int i = 0; i < 200; i++) begin
            a = int'($urandom_range(0, 16'hFFFF));
            case (i % 5)
                0: b = 1;
                1: b = a;
                2: begin
                    a = int'($urandom_range(0, 16'hFFFE));
                    b = int'($urandom_range(a + 1, 16'hFFFF));
                end
                3: b = int'($urandom_range(1, 255));
                default: b = int'($urandom_range(0, 16'hFFFF));
            endcase
            if (i % 40 == 7) b = 0;
            start_op(a[15:0], b[15:0]);
            wait_result(lat);
            if (b == 0) begin
                ok = (out_valid === 1'b1) && (quotient === 16'hFFFF)
                     && (remainder === a[15:0]) && (div_zero === 1'b1);
            end else begin
                prod = longint'(quotient) * longint'(b) + longint'(remainder);
                ok = (out_valid === 1'b1) && (prod == longint'(a)) && (int'(remainder) < b)
                     && (div_zero === 1'b0) && (int'(quotient) == a / b);
            end
            n_assert++;
            if (!ok) begin
                n_fail++;
                $display("FAIL sweep[%0d] %0d/%0d: ov=%b q=%0d r=%0d dz=%b", i, a, b,
                         out_valid, quotient, remainder, div_zero);
            end
            ack_result();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_div_zero();
        test_stall();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_divider16.md
Name: seq_divider16

Overview:
- Multi-cycle unsigned 16-bit restoring divider for the arithmetic unit.
- Computes quotient and remainder by repeated trial subtraction, one quotient bit per cycle.
- The subtract path reuses the team's carry-lookahead adder, fed with an inverted divisor and a carry-in of 1.
- Sits beside the adder in the ALU and handles DIV/REM operations through a valid/ready handshake.

Parameters:
- WIDTH, 16, operand, quotient and remainder width. Only 16 is verified.
- CNT_W, 5, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands present this cycle
- in_ready  output  1  block can accept operands (high only in IDLE)
- dividend  input  WIDTH  unsigned dividend, sampled at accept
- divisor  input  WIDTH  unsigned divisor, sampled at accept
- out_valid  output  1  result valid (high only in DONE)
- out_ready  input  1  consumer takes the result
- quotient  output  WIDTH  quotient
- remainder  output  WIDTH  remainder
- div_zero  output  1  divisor was zero for this result

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; quotient, remainder and counter = 0.
  - div_zero=0, out_valid=0, in_ready=1.
- States: IDLE, RUN, DONE. Encoded per the shared package.
- IDLE:
  - Accept occurs when in_valid & in_ready.
  - On accept, latch the divisor into reg D, the dividend into the Q register, clear the partial remainder R (WIDTH+1 bits), and set counter=WIDTH.
  - If divisor==0 at accept, go to DONE next cycle with quotient=all-ones, remainder=dividend, div_zero=1. RUN is skipped.
  - Otherwise go to RUN.
- RUN, each cycle:
  - Shift {R,Q} left by 1.
  - Compute T = R_shifted - {0,D} with a (WIDTH+1)-bit subtract.
  - If T is non-negative (carry-out = 1): R=T and Q[0]=1. Else: R unchanged (restored) and Q[0]=0.
  - Decrement the counter. When the counter reaches 0 after the update, go to DONE.
- DONE:
  - out_valid=1. quotient=Q, remainder=R[WIDTH-1:0], div_zero=0 for normal results.
  - Outputs are held stable while out_ready=0.
  - On out_ready=1, go to IDLE. out_valid drops the following cycle.
- Latency:
  - Normal: accept in cycle t, out_valid asserted in cycle t+WIDTH+1 (t+17).
  - Divide by zero: out_valid in cycle t+1.
- in_valid while not in IDLE: ignored, no side effect, operands not captured.
- Back-to-back: no new accept in the same cycle as the DONE→IDLE handoff. The earliest next accept is the cycle after.
- quotient/remainder/div_zero are only guaranteed meaningful while out_valid=1. They hold their last value otherwise.
- Reset mid-RUN or mid-DONE: the operation is abandoned and all outputs return to reset values immediately.
- Arithmetic: all unsigned. The remainder is always < divisor for divisor≠0. The identity dividend = quotient·divisor + remainder must hold.

Decomposition:
- Shared package (alu_pkg):
  - WIDTH constant.
  - State encoding constants DIV_IDLE=2'd0, DIV_RUN=2'd1, DIV_DONE=2'd2.
  - DIV_ZERO_QUOT constant = all-ones.
- One sub-module, sub17bits: combinational (WIDTH+1)-bit subtractor built as A + ~B + 1 on carry-lookahead adder cells. Outputs the difference and the borrow-free flag (carry-out).
- FSM, counter and shift registers live in seq_divider16.

Test Plan:
- 100 / 7 → out_valid exactly 17 cycles after accept; quotient=14, remainder=2, div_zero=0.
- 0xFFFF / 1 → quotient=0xFFFF, remainder=0. Then 3 / 10 → quotient=0, remainder=3.
- 5 / 0 → out_valid 1 cycle after accept; quotient=0xFFFF, remainder=5, div_zero=1.
- 1000 / 33 with out_ready held low 5 cycles and in_valid pulsed with other operands during RUN/DONE:
  - quotient=30, remainder=10, held stable across the stall.
  - The extra in_valid is ignored and in_ready=0 until the cycle after out_ready.
- Assert rst_n low at RUN iteration 8 of 0x8000 / 3:
  - All outputs go to reset values without waiting for a clock edge.
  - After release, 0x8000 / 3 → quotient=0x2AAA, remainder=2.
- Randomized back-to-back sweep: 200 random pairs including divisor=1, divisor=dividend and divisor>dividend. Each result is checked against the division identity and div_zero rules.
